// File: rtl/conversor_bcd_binario_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble: shift right,
// then subtract 3 from each digit >= 8), with start/busy/done handshake.
module conversor_bcd_binario_seq #(
    parameter int DIGITOS    = 3,
    parameter int LARG_INT   = 10,
    parameter int LARG_SAIDA = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    Inicio,
    input  logic [4*DIGITOS-1:0]    EntradaBCD,
    output logic [LARG_SAIDA-1:0]   Binario,
    output logic                    Ocupado,
    output logic                    Pronto,
    output logic                    Overflow,
    output logic                    Erro
);

    localparam int LARG_BCD  = 4 * DIGITOS;
    localparam int LARG_TRAB = LARG_BCD + LARG_INT;
    localparam int LARG_CONT = $clog2(LARG_INT + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} estado_t;

    estado_t                estado;
    estado_t                proximo;
    logic [LARG_TRAB-1:0]   trab;
    logic [LARG_TRAB-1:0]   trab_prox;
    logic [LARG_INT-1:0]    bin_prox;
    logic [LARG_CONT-1:0]   contador;
    logic                   erro_pend;
    logic                   entrada_invalida;
    logic                   ultima;
    logic                   excede;

    always_comb begin
        entrada_invalida = 1'b0;
        for (int i = 0; i < DIGITOS; i++) begin
            if (EntradaBCD[4*i +: 4] > 4'd9) begin
                entrada_invalida = 1'b1;
            end
        end
    end

    // One conversion step: the correction acts on the already-shifted digits.
    always_comb begin
        trab_prox = trab >> 1;
        for (int i = 0; i < DIGITOS; i++) begin
            if (trab_prox[LARG_INT + 4*i +: 4] >= 4'd8) begin
                trab_prox[LARG_INT + 4*i +: 4] = trab_prox[LARG_INT + 4*i +: 4] - 4'd3;
            end
        end
    end

    assign bin_prox = trab_prox[LARG_INT-1:0];
    assign excede   = (bin_prox >> LARG_SAIDA) != '0;
    assign ultima   = (contador == LARG_CONT'(LARG_INT - 1));
    assign Ocupado  = (estado != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= IDLE;
        end else begin
            estado <= proximo;
        end
    end

    // An invalid operand spends one IDLE cycle flagged as pending before DONE.
    always_comb begin
        proximo = estado;
        case (estado)
            IDLE: begin
                if (erro_pend) begin
                    proximo = DONE;
                end else if (Inicio && !entrada_invalida) begin
                    proximo = CONV;
                end
            end
            CONV: begin
                if (ultima) begin
                    proximo = DONE;
                end
            end
            DONE:    proximo = IDLE;
            default: proximo = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trab      <= '0;
            contador  <= '0;
            erro_pend <= 1'b0;
            Binario   <= '0;
            Overflow  <= 1'b0;
            Erro      <= 1'b0;
            Pronto    <= 1'b0;
        end else begin
            Pronto <= (proximo == DONE);
            case (estado)
                IDLE: begin
                    if (erro_pend) begin
                        erro_pend <= 1'b0;
                        Erro      <= 1'b1;
                        Binario   <= '0;
                        Overflow  <= 1'b0;
                    end else if (Inicio) begin
                        trab      <= {EntradaBCD, {LARG_INT{1'b0}}};
                        contador  <= '0;
                        erro_pend <= entrada_invalida;
                    end
                end
                CONV: begin
                    trab     <= trab_prox;
                    contador <= contador + LARG_CONT'(1);
                    if (ultima) begin
                        Erro <= 1'b0;
                        if (excede) begin
                            Overflow <= 1'b1;
                            Binario  <= '1;
                        end else begin
                            Overflow <= 1'b0;
                            Binario  <= bin_prox[LARG_SAIDA-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conversor_bcd_binario_seq.sv
// Self-checking bench for conversor_bcd_binario_seq: directed cases from the
// test plan plus random operands checked against a decimal-arithmetic model.
module tb_conversor_bcd_binario_seq;

    logic        clk;
    logic        rst_n;
    logic        Inicio;
    logic [11:0] EntradaBCD;
    logic [7:0]  Binario;
    logic        Ocupado;
    logic        Pronto;
    logic        Overflow;
    logic        Erro;

    int checks = 0;
    int errors = 0;

    conversor_bcd_binario_seq #(
        .DIGITOS(3),
        .LARG_INT(10),
        .LARG_SAIDA(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Inicio(Inicio),
        .EntradaBCD(EntradaBCD),
        .Binario(Binario),
        .Ocupado(Ocupado),
        .Pronto(Pronto),
        .Overflow(Overflow),
        .Erro(Erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal value of the digits, saturated to 8 bits.
    task automatic refModel(input logic [11:0] bcd, output int bin, output int ovf, output int err);
        int d0, d1, d2, val;
        d0 = int'(bcd[3:0]);
        d1 = int'(bcd[7:4]);
        d2 = int'(bcd[11:8]);
        err = (d0 > 9 || d1 > 9 || d2 > 9) ? 1 : 0;
        val = d2 * 100 + d1 * 10 + d0;
        if (err == 1) begin
            bin = 0;
            ovf = 0;
        end else if (val > 255) begin
            bin = 255;
            ovf = 1;
        end else begin
            bin = val;
            ovf = 0;
        end
    endtask

    task automatic startReq(input logic [11:0] bcd);
        @(negedge clk);
        Inicio     = 1'b1;
        EntradaBCD = bcd;
        @(posedge clk);
        #1;
        Inicio = 1'b0;
    endtask

    task automatic waitPronto(output int cyc, output int busy);
        cyc  = -1;
        busy = Ocupado ? 1 : 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (Ocupado) busy++;
            if (Pronto) begin
                cyc = i;
                return;
            end
        end
    endtask

    task automatic countPronto(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (Pronto) seen++;
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [11:0] bcd);
        int eb, eo, ee, cyc, busy;
        refModel(bcd, eb, eo, ee);
        startReq(bcd);
        waitPronto(cyc, busy);
        checkOutput({tag, "_latency"}, cyc, (ee == 1) ? 1 : 10);
        checkOutput({tag, "_busy"}, busy, (ee == 1) ? 1 : 11);
        checkOutput({tag, "_binario"}, {24'd0, Binario}, eb);
        checkOutput({tag, "_overflow"}, {31'd0, Overflow}, eo);
        checkOutput({tag, "_erro"}, {31'd0, Erro}, ee);
        @(posedge clk);
        #1;
        checkOutput({tag, "_pronto_drop"}, {31'd0, Pronto}, 0);
        checkOutput({tag, "_busy_drop"}, {31'd0, Ocupado}, 0);
    endtask

    initial begin
        int cyc, busy, seen;
        logic [11:0] rnd;
        rst_n      = 1'b1;
        Inicio     = 1'b0;
        EntradaBCD = 12'h000;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_binario", {24'd0, Binario}, 0);
        checkOutput("rst_flags", {28'd0, Ocupado, Pronto, Overflow, Erro}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        applyStimulus("zero", 12'h000);
        applyStimulus("max", 12'h255);
        applyStimulus("half", 12'h128);
        applyStimulus("ovf256", 12'h256);
        applyStimulus("ovf999", 12'h999);
        applyStimulus("invalid", 12'h1A3);
        applyStimulus("after_err", 12'h042);

        // Re-request and operand change during CONV must be ignored.
        startReq(12'h100);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        Inicio     = 1'b1;
        EntradaBCD = 12'h007;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        Inicio = 1'b0;
        waitPronto(cyc, busy);
        checkOutput("repulse_latency", cyc, 5);
        checkOutput("repulse_binario", {24'd0, Binario}, 32'h64);
        countPronto(15, seen);
        checkOutput("repulse_single", seen, 0);

        // Asynchronous abort mid-conversion.
        startReq(12'h200);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("abort_binario", {24'd0, Binario}, 0);
        checkOutput("abort_flags", {28'd0, Ocupado, Pronto, Overflow, Erro}, 0);
        @(negedge clk) rst_n = 1'b1;
        countPronto(15, seen);
        checkOutput("abort_no_pronto", seen, 0);
        applyStimulus("after_abort", 12'h200);

        for (int k = 0; k < 24; k++) begin
            rnd[3:0]  = 4'($urandom_range(0, 9));
            rnd[7:4]  = 4'($urandom_range(0, 9));
            rnd[11:8] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 5) == 0) rnd[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
            applyStimulus("random", rnd);
        end

        $display("[TB] done");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
